// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Define HAZ_PERF_EN to build the saturating load-use / branch stall counters.
module hazard_ctrl #(
    parameter int unsigned RW = 5,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] RsD,
    input  logic [RW-1:0] RtD,
    input  logic [RW-1:0] RsE,
    input  logic [RW-1:0] RtE,
    input  logic [RW-1:0] WriteRegE,
    input  logic [RW-1:0] WriteRegM,
    input  logic [RW-1:0] WriteRegW,
    input  logic          RegWriteD,
    input  logic          MemToRegD,
    input  logic          BranchD,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushE,
    output logic          ForwardAD,
    output logic          ForwardBD,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          RegWriteW,
    output logic          MemToRegW,
    output logic [CW-1:0] LoadStallCnt,
    output logic [CW-1:0] BranchStallCnt
);

    logic reg_write_e, mem_to_reg_e;
    logic reg_write_m, mem_to_reg_m;
    logic reg_write_w, mem_to_reg_w;
    logic lwstall, brstall, stall;
    logic e_hits_d, m_hits_d;

    always_comb begin
        e_hits_d = (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
        m_hits_d = (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD));
        lwstall  = mem_to_reg_e && reg_write_e && e_hits_d;
        brstall  = BranchD && ((reg_write_e && e_hits_d) || (mem_to_reg_m && m_hits_d));
        stall    = lwstall || brstall;
    end

    // The flush that accompanies every stall is what turns the held D instruction into an E bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end else begin
            reg_write_e  <= stall ? 1'b0 : RegWriteD;
            mem_to_reg_e <= stall ? 1'b0 : MemToRegD;
            reg_write_m  <= reg_write_e;
            mem_to_reg_m <= mem_to_reg_e;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
        end
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = 2'd0;
        ForwardBE = 2'd0;
        RegWriteW = 1'b0;
        MemToRegW = 1'b0;
        if (!reset) begin
            StallF    = stall;
            StallD    = stall;
            FlushE    = stall;
            ForwardAD = (RsD != '0) && reg_write_m && (WriteRegM == RsD);
            ForwardBD = (RtD != '0) && reg_write_m && (WriteRegM == RtD);
            if ((RsE != '0) && reg_write_m && (WriteRegM == RsE))
                ForwardAE = 2'd2;
            else if ((RsE != '0) && reg_write_w && (WriteRegW == RsE))
                ForwardAE = 2'd1;
            if ((RtE != '0) && reg_write_m && (WriteRegM == RtE))
                ForwardBE = 2'd2;
            else if ((RtE != '0) && reg_write_w && (WriteRegW == RtE))
                ForwardBE = 2'd1;
            RegWriteW = reg_write_w;
            MemToRegW = mem_to_reg_w;
        end
    end

`ifdef HAZ_PERF_EN
    logic [CW-1:0] load_cnt, branch_cnt;

    // A cycle with both stall causes is charged to load-use only.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt   <= '0;
            branch_cnt <= '0;
        end else begin
            if (lwstall && (load_cnt != '1))
                load_cnt <= load_cnt + CW'(1);
            if (brstall && !lwstall && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CW'(1);
        end
    end

    assign LoadStallCnt   = reset ? '0 : load_cnt;
    assign BranchStallCnt = reset ? '0 : branch_cnt;
`else
    assign LoadStallCnt   = '0;
    assign BranchStallCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; counters checked against HAZ_PERF_EN setting.
module tb_hazard_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;
`ifdef HAZ_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic          RegWriteD, MemToRegD, BranchD;
    logic          StallF, StallD, FlushE, ForwardAD, ForwardBD, RegWriteW, MemToRegW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] LoadStallCnt, BranchStallCnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.RW(RW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .BranchD(BranchD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .LoadStallCnt(LoadStallCnt), .BranchStallCnt(BranchStallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteD = 1'b0; MemToRegD = 1'b0; BranchD = 1'b0;
    endtask

    task automatic do_reset();
        zero_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_stall(input string tag, input int exp);
        check({tag, "_stallf"}, 32'(StallF), 32'(exp));
        check({tag, "_stalld"}, 32'(StallD), 32'(exp));
        check({tag, "_flushe"}, 32'(FlushE), 32'(exp));
    endtask

    initial begin
        zero_inputs();
        // Reset with hazard-looking inputs present: everything must read 0.
        reset = 1'b1;
        RegWriteD = 1'b1; MemToRegD = 1'b1; BranchD = 1'b1;
        RsD = 5'd3; RsE = 5'd3; WriteRegE = 5'd3; WriteRegM = 5'd3; WriteRegW = 5'd3;
        tick();
        tick();
        #1;
        chk_stall("rst", 0);
        check("rst_fae", 32'(ForwardAE), 0);
        check("rst_fad", 32'(ForwardAD), 0);
        check("rst_rww", 32'(RegWriteW), 0);
        check("rst_m2rw", 32'(MemToRegW), 0);
        check("rst_lcnt", 32'(LoadStallCnt), 0);

        // Latency: RegWriteD held at 1 reaches W three edges after reset drops.
        zero_inputs();
        RegWriteD = 1'b1;
        reset = 1'b0;
        #1 check("lat0", 32'(RegWriteW), 0);
        tick(); #1 check("lat1", 32'(RegWriteW), 0);
        tick(); #1 check("lat2", 32'(RegWriteW), 0);
        tick(); #1 check("lat3", 32'(RegWriteW), 1);
        tick();

        // add $3 then sub using $3: M forward, then W forward.
        do_reset();
        RegWriteD = 1'b1;
        tick();
        RegWriteD = 1'b0; WriteRegE = 5'd3;
        tick();
        WriteRegE = 5'd0; WriteRegM = 5'd3; RsE = 5'd3; RsD = 5'd3;
        #1;
        check("fwd_ae_m", 32'(ForwardAE), 2);
        check("fwd_be_0", 32'(ForwardBE), 0);
        check("fwd_ad_m", 32'(ForwardAD), 1);
        tick();
        RsD = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd3;
        #1;
        check("fwd_ae_w", 32'(ForwardAE), 1);
        check("fwd_rww", 32'(RegWriteW), 1);

        // Two writes to $7 in M and W: M takes priority.
        do_reset();
        RegWriteD = 1'b1;
        tick();
        tick();
        RegWriteD = 1'b0;
        tick();
        WriteRegM = 5'd7; WriteRegW = 5'd7; RtE = 5'd7; RsE = 5'd7;
        #1;
        check("prio_be", 32'(ForwardBE), 2);
        check("prio_ae", 32'(ForwardAE), 2);

        // lw $5 then add using $5: exactly one stall cycle, then W forward.
        do_reset();
        RegWriteD = 1'b1; MemToRegD = 1'b1;
        tick();
        MemToRegD = 1'b0; WriteRegE = 5'd5; RtD = 5'd5;
        #1 chk_stall("lu1", 1);
        tick();
        WriteRegE = 5'd0; WriteRegM = 5'd5;
        #1 chk_stall("lu2", 0);
        tick();
        RtD = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd5; RtE = 5'd5;
        #1;
        check("lu_fbe", 32'(ForwardBE), 1);
        check("lu_m2rw", 32'(MemToRegW), 1);
        check("lu_lcnt", 32'(LoadStallCnt), 32'(PERF));
        check("lu_bcnt", 32'(BranchStallCnt), 0);

        // lw $2 then beq on $2: two stall cycles, load-use then branch.
        do_reset();
        RegWriteD = 1'b1; MemToRegD = 1'b1;
        tick();
        RegWriteD = 1'b0; MemToRegD = 1'b0; BranchD = 1'b1; RsD = 5'd2; WriteRegE = 5'd2;
        #1 chk_stall("br1", 1);
        tick();
        WriteRegE = 5'd0; WriteRegM = 5'd2;
        #1 chk_stall("br2", 1);
        tick();
        WriteRegM = 5'd0; WriteRegW = 5'd2;
        #1;
        chk_stall("br3", 0);
        check("br_fad", 32'(ForwardAD), 0);
        check("br_lcnt", 32'(LoadStallCnt), 32'(PERF));
        check("br_bcnt", 32'(BranchStallCnt), 32'(PERF));

        // Loads/branches all targeting $0: no hazards anywhere.
        do_reset();
        RegWriteD = 1'b1; MemToRegD = 1'b1; BranchD = 1'b1;
        tick(); tick(); tick();
        #1;
        chk_stall("z0", 0);
        check("z0_fae", 32'(ForwardAE), 0);
        check("z0_fbe", 32'(ForwardBE), 0);
        check("z0_fad", 32'(ForwardAD), 0);
        check("z0_fbd", 32'(ForwardBD), 0);
        check("z0_rww", 32'(RegWriteW), 1);
        check("z0_m2rw", 32'(MemToRegW), 1);

        // Reset during a load-use stall with loads in flight.
        do_reset();
        RegWriteD = 1'b1; MemToRegD = 1'b1;
        tick();
        WriteRegE = 5'd9;
        tick();
        RegWriteD = 1'b1; MemToRegD = 1'b0; RtD = 5'd5; WriteRegE = 5'd5; WriteRegM = 5'd9;
        #1 chk_stall("rs_pre", 1);
        reset = 1'b1;
        #1 chk_stall("rs_in", 0);
        tick();
        zero_inputs();
        reset = 1'b0;
        #1 check("rs_w0", 32'(RegWriteW), 0);
        tick(); #1 check("rs_w1", 32'(RegWriteW), 0);
        check("rs_m1", 32'(MemToRegW), 0);
        tick(); #1 check("rs_w2", 32'(RegWriteW), 0);
        check("rs_m2", 32'(MemToRegW), 0);

        // Twenty load-use stalls: counter saturates at 2^CW-1.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            zero_inputs();
            RegWriteD = 1'b1; MemToRegD = 1'b1;
            tick();
            MemToRegD = 1'b0; RegWriteD = 1'b0; WriteRegE = 5'd5; RtD = 5'd5;
            tick();
            WriteRegE = 5'd0; RtD = 5'd0;
            tick();
            if (i == 2) check("sat_3", 32'(LoadStallCnt), 32'(3 * PERF));
        end
        #1;
        check("sat_max", 32'(LoadStallCnt), 32'(15 * PERF));
        check("sat_bcnt", 32'(BranchStallCnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
